// File: rtl/locallink_tx_pkg.sv
// rtl/locallink_tx_pkg.sv - shared types and constants for the LocalLink TX framer
package locallink_tx_pkg;

    typedef enum logic [2:0] {
        FILL,
        DROP,
        TX_PRIME,
        TX,
        GAP
    } state_e;

    localparam int BUF_ADDR_WIDTH_DFLT = 11;
    localparam int BUF_DEPTH           = 2 ** BUF_ADDR_WIDTH_DFLT;
    localparam int LEN_WIDTH           = BUF_ADDR_WIDTH_DFLT + 1;

    localparam logic [7:0] PAD_BYTE = 8'h00;

endpackage

// File: rtl/locallink_tx_framer_ram.sv
// rtl/locallink_tx_framer_ram.sv - byte-wide simple dual-port frame buffer, 1-cycle synchronous read
module frame_buffer_ram #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [7:0]            wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [7:0]            rd_data
);

    logic [7:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/locallink_tx_framer.sv
// rtl/locallink_tx_framer.sv - store-and-forward LocalLink to byte-wide MAC TX bridge with padding and IFG
module locallink_tx_framer
    import locallink_tx_pkg::*;
#(
    parameter int BUF_ADDR_WIDTH  = BUF_ADDR_WIDTH_DFLT,
    parameter int MIN_FRAME_BYTES = 60,
    parameter int IFG_CYCLES      = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ll_data_in,
    input  logic       ll_sof_in_n,
    input  logic       ll_eof_in_n,
    input  logic       ll_src_rdy_in_n,
    output logic       ll_dst_rdy_out_n,
    output logic [7:0] tx_data,
    output logic       tx_enable,
    output logic       frame_sent,
    output logic       frame_dropped
);

    localparam int DEPTH = 2 ** BUF_ADDR_WIDTH;
    localparam int LW    = BUF_ADDR_WIDTH + 1;
    localparam int GW    = $clog2(IFG_CYCLES + 1);

    state_e              state_q, state_d;
    logic [LW-1:0]       len_q, len_d;
    logic [LW-1:0]       idx_q, idx_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic                dst_rdy_n_q, dst_rdy_n_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_enable_q, tx_enable_d;
    logic                frame_sent_q, frame_sent_d;
    logic                frame_dropped_q, frame_dropped_d;

    logic                      wr_en, rd_en;
    logic [BUF_ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic [7:0]                rd_data;
    logic                      beat, sof, eof;
    logic [LW-1:0]             tx_len;

    assign beat   = !ll_src_rdy_in_n && !dst_rdy_n_q;
    assign sof    = !ll_sof_in_n;
    assign eof    = !ll_eof_in_n;
    assign tx_len = (len_q < LW'(MIN_FRAME_BYTES)) ? LW'(MIN_FRAME_BYTES) : len_q;

    frame_buffer_ram #(
        .ADDR_WIDTH(BUF_ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(ll_data_in),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        idx_d           = idx_q;
        gap_d           = gap_q;
        tx_data_d       = PAD_BYTE;
        tx_enable_d     = 1'b0;
        frame_sent_d    = 1'b0;
        frame_dropped_d = 1'b0;
        wr_en           = 1'b0;
        wr_addr         = len_q[BUF_ADDR_WIDTH-1:0];
        rd_en           = 1'b0;
        rd_addr         = idx_q[BUF_ADDR_WIDTH-1:0] + BUF_ADDR_WIDTH'(1);

        case (state_q)
            FILL: begin
                // len_q==0 means no sof seen yet, so stray beats fall through
                if (beat) begin
                    if (sof) begin
                        wr_en   = 1'b1;
                        wr_addr = '0;
                        len_d   = LW'(1);
                        if (eof) state_d = TX_PRIME;
                    end else if (len_q != '0) begin
                        if (len_q == LW'(DEPTH)) begin
                            if (eof) begin
                                frame_dropped_d = 1'b1;
                                len_d           = '0;
                            end else begin
                                state_d = DROP;
                            end
                        end else begin
                            wr_en = 1'b1;
                            len_d = len_q + LW'(1);
                            if (eof) state_d = TX_PRIME;
                        end
                    end
                end
            end
            DROP: begin
                if (beat && eof) begin
                    frame_dropped_d = 1'b1;
                    len_d           = '0;
                    state_d         = FILL;
                end
            end
            TX_PRIME: begin
                rd_en   = 1'b1;
                rd_addr = '0;
                idx_d   = '0;
                state_d = TX;
            end
            TX: begin
                // rd_data holds byte idx_q; fetch idx_q+1 for the next cycle
                rd_en       = 1'b1;
                tx_enable_d = 1'b1;
                tx_data_d   = (idx_q < len_q) ? rd_data : PAD_BYTE;
                idx_d       = idx_q + LW'(1);
                if (idx_q == tx_len - LW'(1)) begin
                    frame_sent_d = 1'b1;
                    len_d        = '0;
                    gap_d        = '0;
                    state_d      = GAP;
                end
            end
            GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GW'(IFG_CYCLES - 1)) state_d = FILL;
            end
            default: state_d = FILL;
        endcase

        dst_rdy_n_d = !((state_d == FILL) || (state_d == DROP));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= FILL;
            len_q           <= '0;
            idx_q           <= '0;
            gap_q           <= '0;
            dst_rdy_n_q     <= 1'b1;
            tx_data_q       <= '0;
            tx_enable_q     <= 1'b0;
            frame_sent_q    <= 1'b0;
            frame_dropped_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            len_q           <= len_d;
            idx_q           <= idx_d;
            gap_q           <= gap_d;
            dst_rdy_n_q     <= dst_rdy_n_d;
            tx_data_q       <= tx_data_d;
            tx_enable_q     <= tx_enable_d;
            frame_sent_q    <= frame_sent_d;
            frame_dropped_q <= frame_dropped_d;
        end
    end

    assign ll_dst_rdy_out_n = dst_rdy_n_q;
    assign tx_data          = tx_data_q;
    assign tx_enable        = tx_enable_q;
    assign frame_sent       = frame_sent_q;
    assign frame_dropped    = frame_dropped_q;

endmodule

// File: tb/tb_locallink_tx_framer.sv
// tb/tb_locallink_tx_framer.sv - directed scoreboard bench for locallink_tx_framer
module tb_locallink_tx_framer;

    localparam int IFG  = 12;
    localparam int MINB = 60;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ll_data;
    logic       sof_n, eof_n, src_a_n, src_b_n;
    logic       dst_a_n, txe_a, sent_a, drop_a;
    logic       dst_b_n, txe_b, sent_b, drop_b;
    logic [7:0] txd_a, txd_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int eof_cyc = 0;
    int cap_a = 0, cap_b = 0, nsent_a = 0, nsent_b = 0;
    int ndrop_a = 0, ndrop_b = 0, drop_cyc_b = 0;
    logic [7:0] exp_a[$], exp_b[$];
    int elen_a[$], elen_b[$], first_a[$], last_a[$], first_b[$], last_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    locallink_tx_framer dut (
        .clk(clk), .reset(reset), .ll_data_in(ll_data), .ll_sof_in_n(sof_n),
        .ll_eof_in_n(eof_n), .ll_src_rdy_in_n(src_a_n), .ll_dst_rdy_out_n(dst_a_n),
        .tx_data(txd_a), .tx_enable(txe_a), .frame_sent(sent_a), .frame_dropped(drop_a)
    );

    locallink_tx_framer #(.BUF_ADDR_WIDTH(6)) dut_s (
        .clk(clk), .reset(reset), .ll_data_in(ll_data), .ll_sof_in_n(sof_n),
        .ll_eof_in_n(eof_n), .ll_src_rdy_in_n(src_b_n), .ll_dst_rdy_out_n(dst_b_n),
        .tx_data(txd_b), .tx_enable(txe_b), .frame_sent(sent_b), .frame_dropped(drop_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (txe_a) begin
                if (cap_a == 0) first_a.push_back(cyc);
                if (exp_a.size() == 0) check("unexpected_byte_a", 1, 0);
                else check("byte_a", {24'd0, txd_a}, {24'd0, exp_a.pop_front()});
                cap_a++;
                if (sent_a) begin
                    if (elen_a.size() == 0) check("unexpected_sent_a", 1, 0);
                    else check("len_a", cap_a, elen_a.pop_front());
                    last_a.push_back(cyc);
                    nsent_a++;
                    cap_a = 0;
                end
            end else begin
                check("idle_data_a", {24'd0, txd_a}, 0);
                check("idle_sent_a", {31'd0, sent_a}, 0);
            end
            if (drop_a) ndrop_a++;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (txe_b) begin
                if (cap_b == 0) first_b.push_back(cyc);
                if (exp_b.size() == 0) check("unexpected_byte_b", 1, 0);
                else check("byte_b", {24'd0, txd_b}, {24'd0, exp_b.pop_front()});
                cap_b++;
                if (sent_b) begin
                    if (elen_b.size() == 0) check("unexpected_sent_b", 1, 0);
                    else check("len_b", cap_b, elen_b.pop_front());
                    last_b.push_back(cyc);
                    nsent_b++;
                    cap_b = 0;
                end
            end else begin
                check("idle_data_b", {24'd0, txd_b}, 0);
                check("idle_sent_b", {31'd0, sent_b}, 0);
            end
            if (drop_b) begin
                ndrop_b++;
                drop_cyc_b = cyc;
            end
        end
    end

    task automatic hold(input int k);
        @(negedge clk);
        src_a_n = 1'b1;
        src_b_n = 1'b1;
        sof_n   = 1'b1;
        eof_n   = 1'b1;
        repeat (k - 1) @(negedge clk);
    endtask

    task automatic send_beat(input bit sel, input logic [7:0] d, input bit sof, input bit eof);
        int budget = 0;
        @(negedge clk);
        ll_data = d;
        sof_n   = !sof;
        eof_n   = !eof;
        src_a_n = sel;
        src_b_n = !sel;
        while ((sel ? dst_b_n : dst_a_n) !== 1'b0) begin
            @(negedge clk);
            budget++;
            if (budget > 500) begin
                check("accept_timeout", 1, 0);
                return;
            end
        end
        if (eof) eof_cyc = cyc + 1;
        @(posedge clk);
    endtask

    task automatic send_frame(input bit sel, input int n, input logic [7:0] base,
                              input bit stall, input int depth);
        if (n <= depth) begin
            for (int i = 0; i < ((n < MINB) ? MINB : n); i++) begin
                if (sel) exp_b.push_back((i < n) ? base + 8'(i) : 8'h00);
                else     exp_a.push_back((i < n) ? base + 8'(i) : 8'h00);
            end
            if (sel) elen_b.push_back((n < MINB) ? MINB : n);
            else     elen_a.push_back((n < MINB) ? MINB : n);
        end
        for (int i = 0; i < n; i++) begin
            send_beat(sel, base + 8'(i), i == 0, i == n - 1);
            if (stall && (i % 2 == 1) && (i != n - 1)) hold(3);
        end
    endtask

    task automatic wait_sent(input bit sel, input int target);
        int b = 0;
        while (((sel ? nsent_b : nsent_a) < target) && (b < 3000)) begin
            @(negedge clk);
            b++;
        end
        check("sent_count", sel ? nsent_b : nsent_a, target);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, f, l, f2, l2, b, ns;
        reset   = 1'b1;
        src_a_n = 1'b1;
        src_b_n = 1'b1;
        sof_n   = 1'b1;
        eof_n   = 1'b1;
        ll_data = 8'h00;
        #3;
        check("rst_dst_rdy", {31'd0, dst_a_n}, 1);
        check("rst_tx_enable", {31'd0, txe_a}, 0);
        check("rst_tx_data", {24'd0, txd_a}, 0);
        check("rst_sent", {31'd0, sent_a}, 0);
        check("rst_dropped", {31'd0, drop_a}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1 check("dst_before_edge", {31'd0, dst_a_n}, 1);
        @(posedge clk);
        #1 check("dst_after_release", {31'd0, dst_a_n}, 0);

        // 64-byte frame, timing of first/last byte and of dst_rdy through the gap
        send_frame(0, 64, 8'h00, 0, 2048);
        n = eof_cyc;
        hold(1);
        check("dst_busy_after_eof", {31'd0, dst_a_n}, 1);
        wait_sent(0, 1);
        f = first_a.pop_front();
        l = last_a.pop_front();
        check("t1_first", f, n + 2);
        check("t1_last", l, n + 65);
        b = 0;
        while (dst_a_n !== 1'b0 && b < 200) begin
            @(negedge clk);
            b++;
        end
        check("t1_dst_free_cyc", cyc, l + IFG);

        // 1-byte frame padded to 60
        send_frame(0, 1, 8'hA5, 0, 2048);
        n = eof_cyc;
        wait_sent(0, 2);
        f = first_a.pop_front();
        l = last_a.pop_front();
        check("t2_first", f, n + 2);
        check("t2_last", l, n + 61);

        // stalled 100-byte source still gives contiguous output
        send_frame(0, 100, 8'h10, 1, 2048);
        n = eof_cyc;
        wait_sent(0, 3);
        f = first_a.pop_front();
        l = last_a.pop_front();
        check("t3_first", f, n + 2);
        check("t3_span", l - f, 99);

        // oversize on the small-buffer instance, then a padded 10-byte frame
        send_frame(1, 70, 8'h40, 0, 64);
        n = eof_cyc;
        hold(3);
        check("t4_drop_count", ndrop_b, 1);
        check("t4_drop_cyc", drop_cyc_b, n);
        send_frame(1, 10, 8'h80, 0, 64);
        wait_sent(1, 1);
        f = first_b.pop_front();
        l = last_b.pop_front();
        check("t4_span", l - f, 59);

        // back-to-back 60-byte frames
        send_frame(0, 60, 8'h20, 0, 2048);
        send_frame(0, 60, 8'h60, 0, 2048);
        wait_sent(0, 5);
        f  = first_a.pop_front();
        l  = last_a.pop_front();
        f2 = first_a.pop_front();
        l2 = last_a.pop_front();
        check("t5_span1", l - f, 59);
        check("t5_spacing", f2 - l, IFG + 3 + 59);
        check("t5_span2", l2 - f2, 59);

        // beats before any sof are discarded
        for (int i = 0; i < 5; i++) send_beat(0, 8'hEE, 0, 0);
        send_frame(0, 4, 8'hC0, 0, 2048);
        n = eof_cyc;
        wait_sent(0, 6);
        f = first_a.pop_front();
        l = last_a.pop_front();
        check("t6_first", f, n + 2);
        check("t6_span", l - f, 59);

        // reset during byte 30 of a 64-byte transmit
        send_frame(0, 64, 8'h00, 0, 2048);
        n = eof_cyc;
        hold(1);
        b = 0;
        while (cyc < n + 32 && b < 200) begin
            @(negedge clk);
            b++;
        end
        check("t6_mid_tx", {31'd0, txe_a}, 1);
        ns = nsent_a;
        #2 reset = 1'b1;
        #1;
        check("t6_rst_tx_enable", {31'd0, txe_a}, 0);
        check("t6_rst_tx_data", {24'd0, txd_a}, 0);
        check("t6_rst_sent", {31'd0, sent_a}, 0);
        check("t6_rst_dst", {31'd0, dst_a_n}, 1);
        exp_a.delete();
        elen_a.delete();
        first_a.delete();
        cap_a = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1 check("t6_dst_pre_edge", {31'd0, dst_a_n}, 1);
        @(posedge clk);
        #1 check("t6_dst_post_edge", {31'd0, dst_a_n}, 0);
        check("t6_no_sent", nsent_a, ns);
        send_frame(0, 5, 8'h33, 0, 2048);
        n = eof_cyc;
        wait_sent(0, ns + 1);
        f = first_a.pop_front();
        check("t6_after_rst_first", f, n + 2);

        hold(20);
        check("left_exp_a", exp_a.size(), 0);
        check("left_exp_b", exp_b.size(), 0);
        check("drops_a", ndrop_a, 0);
        check("drops_b", ndrop_b, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
